// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input in clk cycles.
// A stuck line (no qualifying edge within KTIMEOUT cycles) raises a sticky TIMEOUT flag.
module pwm_capture #(
  parameter  int unsigned KTIMEOUT = 20832,
  localparam int unsigned KCNT_BIT = $clog2(KTIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                PWM_IN,
  output logic [KCNT_BIT-1:0] PERIOD,
  output logic [KCNT_BIT-1:0] HIGH_TIME,
  output logic                MEAS_VALID,
  output logic                TIMEOUT,
  output logic                LEVEL
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              r_state;
  logic                r_s1, r_s2, r_s3;
  logic [KCNT_BIT-1:0] r_cnt;
  logic [KCNT_BIT-1:0] r_high_l;
  logic [KCNT_BIT-1:0] r_period;
  logic [KCNT_BIT-1:0] r_high_time;
  logic                r_valid;
  logic                r_timeout;

  logic                w_rise;
  logic                w_fall;
  logic                w_tmo;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;
  assign w_tmo  = (r_cnt == KCNT_BIT'(KTIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_high_l    <= '0;
      r_period    <= '0;
      r_high_time <= '0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s1    <= PWM_IN;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= HIGH;
            r_cnt   <= KCNT_BIT'(1);
          end
        end
        HIGH: begin
          // An edge in the same cycle as cnt==KTIMEOUT takes priority over the timeout.
          if (w_fall) begin
            r_state  <= LOW;
            r_high_l <= r_cnt;
            r_cnt    <= r_cnt + 1'b1;
          end else if (w_rise) begin
            r_cnt <= KCNT_BIT'(1);
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_state     <= HIGH;
            r_cnt       <= KCNT_BIT'(1);
            r_period    <= r_cnt;
            r_high_time <= r_high_l;
            r_valid     <= 1'b1;
            r_timeout   <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign PERIOD     = r_period;
  assign HIGH_TIME  = r_high_time;
  assign MEAS_VALID = r_valid;
  assign TIMEOUT    = r_timeout;
  assign LEVEL      = r_s2;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: one default instance and one with KTIMEOUT=50.
module tb_pwm_capture;

  localparam int WA = $clog2(20832 + 1);
  localparam int WB = $clog2(50 + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_a, pwm_b;
  logic [WA-1:0] per_a, hi_a;
  logic [WB-1:0] per_b, hi_b;
  logic          mv_a, mv_b, to_a, to_b, lv_a, lv_b;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  pwm_capture dut_a (
    .clk(clk), .rst(rst), .PWM_IN(pwm_a),
    .PERIOD(per_a), .HIGH_TIME(hi_a), .MEAS_VALID(mv_a),
    .TIMEOUT(to_a), .LEVEL(lv_a)
  );

  pwm_capture #(.KTIMEOUT(50)) dut_b (
    .clk(clk), .rst(rst), .PWM_IN(pwm_b),
    .PERIOD(per_b), .HIGH_TIME(hi_b), .MEAS_VALID(mv_b),
    .TIMEOUT(to_b), .LEVEL(lv_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every strobe must match the oldest expected measurement.
  always @(negedge clk) begin
    if (mv_a) begin
      if (qa.size() == 0) begin
        chk("unexpected_strobe_a", 0, 1);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("strobe_cycle_a", cyc, e.cyc);
        chk("period_a", int'(per_a), e.per);
        chk("high_time_a", int'(hi_a), e.hi);
      end
    end
  end

  always @(negedge clk) begin
    if (mv_b) begin
      if (qb.size() == 0) begin
        chk("unexpected_strobe_b", 0, 1);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("strobe_cycle_b", cyc, e.cyc);
        chk("period_b", int'(per_b), e.per);
        chk("high_time_b", int'(hi_b), e.hi);
        chk("timeout_clear_on_strobe_b", int'(to_b), 0);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A strobe follows a rise driven just after edge k at the sampling edge k+3.
  task automatic set_lvl(input bit sel, input bit v, input bit ex, input int per, input int hi);
    exp_t e;
    if (sel) pwm_b = v;
    else     pwm_a = v;
    if (ex) begin
      e.cyc = cyc + 3;
      e.per = per;
      e.hi  = hi;
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  task automatic period(input bit sel, input int h, input int l,
                        input bit ex, input int per, input int hi);
    set_lvl(sel, 1'b1, ex, per, hi);
    wait_cyc(h);
    set_lvl(sel, 1'b0, 1'b0, 0, 0);
    wait_cyc(l);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_period_a"}, int'(per_a), 0);
    chk({tag, "_high_a"}, int'(hi_a), 0);
    chk({tag, "_valid_a"}, int'(mv_a), 0);
    chk({tag, "_timeout_a"}, int'(to_a), 0);
    chk({tag, "_level_a"}, int'(lv_a), 0);
  endtask

  initial begin
    rst   = 1'b1;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    wait_cyc(1);
    for (int i = 0; i < 3; i++) begin
      pwm_a = ~pwm_a;
      pwm_b = ~pwm_b;
      wait_cyc(1);
      chk_zero_a("reset");
      chk("reset_valid_b", int'(mv_b), 0);
      chk("reset_timeout_b", int'(to_b), 0);
    end
    rst   = 1'b0;
    pwm_a = 1'b0;
    pwm_b = 1'b0;
    wait_cyc(5);

    // Steady 30/70: first period discarded, then four strobes.
    period(1'b0, 30, 70, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) period(1'b0, 30, 70, 1'b1, 100, 30);

    // Duty extremes.
    period(1'b0, 1, 99, 1'b1, 100, 30);
    period(1'b0, 99, 1, 1'b1, 100, 1);

    // Reset during a low phase.
    set_lvl(1'b0, 1'b1, 1'b1, 100, 99);
    wait_cyc(30);
    set_lvl(1'b0, 1'b0, 1'b0, 0, 0);
    wait_cyc(20);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk_zero_a("midreset");
    wait_cyc(50);
    period(1'b0, 30, 70, 1'b0, 0, 0);
    period(1'b0, 30, 70, 1'b1, 100, 30);
    set_lvl(1'b0, 1'b1, 1'b1, 100, 30);
    wait_cyc(10);
    set_lvl(1'b0, 1'b0, 1'b0, 0, 0);
    wait_cyc(10);

    // Stuck high with KTIMEOUT=50.
    period(1'b1, 10, 10, 1'b0, 0, 0);
    period(1'b1, 10, 10, 1'b1, 20, 10);
    set_lvl(1'b1, 1'b1, 1'b1, 20, 10);
    wait_cyc(52);
    chk("timeout_before_limit_b", int'(to_b), 0);
    wait_cyc(1);
    chk("timeout_set_b", int'(to_b), 1);
    chk("level_high_b", int'(lv_b), 1);
    chk("period_hold_b", int'(per_b), 20);
    chk("high_hold_b", int'(hi_b), 10);
    wait_cyc(20);
    chk("timeout_sticky_b", int'(to_b), 1);

    // Resume: first period from IDLE gives no strobe and keeps TIMEOUT.
    set_lvl(1'b1, 1'b0, 1'b0, 0, 0);
    wait_cyc(10);
    period(1'b1, 10, 10, 1'b0, 0, 0);
    chk("timeout_kept_idle_to_high_b", int'(to_b), 1);
    period(1'b1, 10, 10, 1'b1, 20, 10);
    chk("timeout_cleared_b", int'(to_b), 0);

    // Rise arrives exactly when cnt==KTIMEOUT: edge wins.
    period(1'b1, 10, 40, 1'b1, 20, 10);
    set_lvl(1'b1, 1'b1, 1'b1, 50, 10);
    wait_cyc(10);
    chk("edge_beats_timeout_b", int'(to_b), 0);
    chk("edge_period_b", int'(per_b), 50);
    set_lvl(1'b1, 1'b0, 1'b0, 0, 0);
    wait_cyc(10);

    chk("pending_strobes_a", qa.size(), 0);
    chk("pending_strobes_b", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
